exec_oprd: RTL and testbench
============================

EXEC_OPRD -- requirements
Module: exec_oprd

Interface
REQ-001 SHALL have these ports (name  direction  width  meaning), clock and reset first:
  iClk  in  1  single clock, all state on rising edge
  iRst_n  in  1  reset, asynchronous, active-low
  iValid  in  1  decode offers an operation
  oReady  out  1  stage can accept an operation this cycle
  iExec  in  3  execution unit select
  iFunc  in  4  unit function code
  iBW  in  1  1 = word, 0 = byte
  iSgn  in  1  signed operation
  iSelOut  in  4  writeback source select, passed through
  iSrc1Mem  in  1  operand 1 from memory, else iRegA
  iSrc2Sel  in  2  operand 2: 0 iRegB, 1 iImm, 2 memory, 3 zero
  iRegA, iRegB, iImm, iEA  in  16  register, immediate and effective-address values
  oMemRd  out  1  memory read request
  oMemAddr  out  16  read address
  iMemAck  in  1  read data valid
  iMemData  in  16  read data
  iFlush  in  1  synchronous pipeline flush
  oValid  out  1  operands valid toward execute
  iExReady  in  1  execute consumes the operation this cycle
  oExec, oFunc, oBW, oSgn, oSelOut  out  3/4/1/1/4  registered copies of the inputs
  R1, R2, oEA  out  16  operands and effective address to execute
  oWaitCnt  out  8  memory wait cycles of the last read, saturating

Function
REQ-002 SHALL implement three states: IDLE, MEMRD, HOLD.
REQ-003 oReady SHALL be 1 in IDLE, and in HOLD when iExReady=1. oReady SHALL be 0 in MEMRD.
REQ-004 An operation is accepted on an edge where iValid=1 and oReady=1. On acceptance, all control inputs and iEA SHALL be registered.
REQ-005 For an accepted operation with no memory operand (iSrc1Mem=0 and iSrc2Sel!=2): R1/R2 SHALL be loaded on the same edge, the state SHALL go to HOLD, and oValid SHALL be 1 on the next cycle (latency 1).
REQ-006 For an accepted operation with a memory operand: the state SHALL go to MEMRD, oMemRd SHALL be 1 and oMemAddr SHALL equal the registered iEA, starting the next cycle and held until iMemAck.
REQ-007 In MEMRD, on an edge with iMemAck=1, iMemData SHALL be loaded into every operand selected from memory, oMemRd SHALL drop, and the state SHALL go to HOLD.
REQ-008 If iMemAck=1 arrives in the same cycle oMemRd is first asserted, the read SHALL complete (zero-wait read).
REQ-009 oWaitCnt SHALL clear on entry to MEMRD and increment on each MEMRD cycle without iMemAck, saturating at 255. It SHALL hold its value outside MEMRD.
REQ-010 Register operands SHALL be sampled at acceptance. Memory operands SHALL be sampled at iMemAck.
REQ-011 Byte mode (iBW=0): the high byte of each operand SHALL be zero when iSgn=0, and sign-extended from bit 7 when iSgn=1. Word mode SHALL pass all 16 bits unchanged.
REQ-012 iSrc2Sel=3 SHALL give R2=0.
REQ-013 In HOLD with iExReady=1 and no new acceptance, the state SHALL go to IDLE and oValid SHALL drop.
REQ-014 In HOLD with iExReady=1 and iValid=1, back-to-back acceptance SHALL occur, with no bubble for register-only operations.
REQ-015 All outputs SHALL remain stable while oValid=1 and iExReady=0.
REQ-016 iFlush=1 SHALL take priority over every other event: the state SHALL go to IDLE, oValid and oMemRd SHALL be 0 on the next cycle, an iMemAck in the same cycle SHALL be ignored, and nothing SHALL be accepted in that cycle.

Reset
REQ-017 While iRst_n=0, asynchronously: state=IDLE, oValid=0, oMemRd=0; oMemAddr, R1, R2, oEA, oExec, oFunc, oSelOut and oWaitCnt = 0; oBW=0, oSgn=0.
REQ-018 Reset during MEMRD SHALL abandon the read. A later iMemAck SHALL be ignored while in IDLE.

Verification
REQ-019 Register op: iRegA=1234h, iRegB=0F0Fh, iSrc2Sel=0, iBW=1 -> one cycle later oValid=1, R1=1234h, R2=0F0Fh.
REQ-020 Memory op: iEA=0200h, iSrc2Sel=2, ack after 3 wait cycles with iMemData=ABCDh -> oMemAddr=0200h, oWaitCnt=3, R2=ABCDh, oValid=1 the cycle after ack.
REQ-021 Byte signed: iBW=0, iSgn=1, iRegA=0085h -> R1=FF85h. With iSgn=0 -> R1=0085h.
REQ-022 Back-pressure: iExReady=0 for 4 cycles while a new iValid is offered -> oReady=0 and outputs unchanged. Then iExReady=1 -> the next operation is accepted that same cycle.
REQ-023 Flush with iMemAck in the same cycle during MEMRD -> next cycle oMemRd=0, oValid=0, state IDLE, operands not updated.
REQ-024 Async reset mid-HOLD -> oValid=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/exec_oprd.sv
// Operand-fetch stage: registers a decoded operation, fetches any memory operand,
// and presents byte/word-extended operands to execute under a ready/valid handshake.
module exec_oprd (
  input  logic        iClk,
  input  logic        iRst_n,
  input  logic        iValid,
  output logic        oReady,
  input  logic [2:0]  iExec,
  input  logic [3:0]  iFunc,
  input  logic        iBW,
  input  logic        iSgn,
  input  logic [3:0]  iSelOut,
  input  logic        iSrc1Mem,
  input  logic [1:0]  iSrc2Sel,
  input  logic [15:0] iRegA,
  input  logic [15:0] iRegB,
  input  logic [15:0] iImm,
  input  logic [15:0] iEA,
  output logic        oMemRd,
  output logic [15:0] oMemAddr,
  input  logic        iMemAck,
  input  logic [15:0] iMemData,
  input  logic        iFlush,
  output logic        oValid,
  input  logic        iExReady,
  output logic [2:0]  oExec,
  output logic [3:0]  oFunc,
  output logic        oBW,
  output logic        oSgn,
  output logic [3:0]  oSelOut,
  output logic [15:0] R1,
  output logic [15:0] R2,
  output logic [15:0] oEA,
  output logic [7:0]  oWaitCnt
);

  typedef enum logic [1:0] {IDLE, MEMRD, HOLD} state_e;

  localparam logic [1:0] SRC2_REGB = 2'd0;
  localparam logic [1:0] SRC2_IMM  = 2'd1;
  localparam logic [1:0] SRC2_MEM  = 2'd2;
  localparam logic [1:0] SRC2_ZERO = 2'd3;

  state_e      state_q, state_d;
  logic [2:0]  exec_q, exec_d;
  logic [3:0]  func_q, func_d;
  logic        bw_q, bw_d;
  logic        sgn_q, sgn_d;
  logic [3:0]  sel_q, sel_d;
  logic        src1mem_q, src1mem_d;
  logic [1:0]  src2sel_q, src2sel_d;
  logic [15:0] ea_q, ea_d;
  logic [15:0] r1_q, r1_d;
  logic [15:0] r2_q, r2_d;
  logic [7:0]  wait_q, wait_d;
  logic        accept;
  logic        mem_op;

  function automatic logic [15:0] extend(input logic [15:0] v, input logic bw, input logic sgn);
    if (bw)       return v;
    else if (sgn) return {{8{v[7]}}, v[7:0]};
    else          return {8'h00, v[7:0]};
  endfunction

  assign oReady = (state_q == IDLE) || ((state_q == HOLD) && iExReady);

  always_comb begin
    // NOTE: every _d takes its hold value first, so no path through this block can infer a latch.
    state_d   = state_q;
    exec_d    = exec_q;
    func_d    = func_q;
    bw_d      = bw_q;
    sgn_d     = sgn_q;
    sel_d     = sel_q;
    src1mem_d = src1mem_q;
    src2sel_d = src2sel_q;
    ea_d      = ea_q;
    r1_d      = r1_q;
    r2_d      = r2_q;
    wait_d    = wait_q;
    accept    = iValid && oReady && !iFlush;
    mem_op    = iSrc1Mem || (iSrc2Sel == SRC2_MEM);

    if (iFlush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, HOLD: begin
          if (accept) begin
            exec_d    = iExec;
            func_d    = iFunc;
            bw_d      = iBW;
            sgn_d     = iSgn;
            sel_d     = iSelOut;
            src1mem_d = iSrc1Mem;
            src2sel_d = iSrc2Sel;
            ea_d      = iEA;
            if (!iSrc1Mem) r1_d = extend(iRegA, iBW, iSgn);
            case (iSrc2Sel)
              SRC2_REGB: r2_d = extend(iRegB, iBW, iSgn);
              SRC2_IMM:  r2_d = extend(iImm, iBW, iSgn);
              SRC2_ZERO: r2_d = '0;
              default:   r2_d = r2_q;
            endcase
            if (mem_op) begin
              state_d = MEMRD;
              wait_d  = '0;
            end else begin
              state_d = HOLD;
            end
          end else if ((state_q == HOLD) && iExReady) begin
            state_d = IDLE;
          end
        end
        MEMRD: begin
          // Memory operands are sampled only here, using the control latched at acceptance.
          if (iMemAck) begin
            if (src1mem_q)              r1_d = extend(iMemData, bw_q, sgn_q);
            if (src2sel_q == SRC2_MEM)  r2_d = extend(iMemData, bw_q, sgn_q);
            state_d = HOLD;
          end else if (wait_q != 8'hFF) begin
            wait_d = wait_q + 8'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q   <= IDLE;
      exec_q    <= '0;
      func_q    <= '0;
      bw_q      <= 1'b0;
      sgn_q     <= 1'b0;
      sel_q     <= '0;
      src1mem_q <= 1'b0;
      src2sel_q <= '0;
      ea_q      <= '0;
      r1_q      <= '0;
      r2_q      <= '0;
      wait_q    <= '0;
    end else begin
      // NOTE: non-blocking updates let every register see the pre-edge values of the others.
      state_q   <= state_d;
      exec_q    <= exec_d;
      func_q    <= func_d;
      bw_q      <= bw_d;
      sgn_q     <= sgn_d;
      sel_q     <= sel_d;
      src1mem_q <= src1mem_d;
      src2sel_q <= src2sel_d;
      ea_q      <= ea_d;
      r1_q      <= r1_d;
      r2_q      <= r2_d;
      wait_q    <= wait_d;
    end
  end

  assign oValid   = (state_q == HOLD);
  assign oMemRd   = (state_q == MEMRD);
  assign oMemAddr = ea_q;
  assign oEA      = ea_q;
  assign oExec    = exec_q;
  assign oFunc    = func_q;
  assign oBW      = bw_q;
  assign oSgn     = sgn_q;
  assign oSelOut  = sel_q;
  assign R1       = r1_q;
  assign R2       = r2_q;
  assign oWaitCnt = wait_q;

endmodule

// File: tb/tb_exec_oprd.sv
// Bench for exec_oprd: directed literal scenarios, then randomized traffic checked
// every cycle against a transaction-level model of the operand stage.
module tb_exec_oprd;

  logic        iClk = 1'b0;
  logic        iRst_n;
  logic        iValid, iBW, iSgn, iSrc1Mem, iMemAck, iFlush, iExReady;
  logic [2:0]  iExec;
  logic [3:0]  iFunc, iSelOut;
  logic [1:0]  iSrc2Sel;
  logic [15:0] iRegA, iRegB, iImm, iEA, iMemData;
  logic        oReady, oMemRd, oValid, oBW, oSgn;
  logic [2:0]  oExec;
  logic [3:0]  oFunc, oSelOut;
  logic [15:0] oMemAddr, R1, R2, oEA;
  logic [7:0]  oWaitCnt;

  exec_oprd dut (
    .iClk(iClk), .iRst_n(iRst_n), .iValid(iValid), .oReady(oReady),
    .iExec(iExec), .iFunc(iFunc), .iBW(iBW), .iSgn(iSgn), .iSelOut(iSelOut),
    .iSrc1Mem(iSrc1Mem), .iSrc2Sel(iSrc2Sel), .iRegA(iRegA), .iRegB(iRegB),
    .iImm(iImm), .iEA(iEA), .oMemRd(oMemRd), .oMemAddr(oMemAddr),
    .iMemAck(iMemAck), .iMemData(iMemData), .iFlush(iFlush), .oValid(oValid),
    .iExReady(iExReady), .oExec(oExec), .oFunc(oFunc), .oBW(oBW), .oSgn(oSgn),
    .oSelOut(oSelOut), .R1(R1), .R2(R2), .oEA(oEA), .oWaitCnt(oWaitCnt)
  );

  always #5 iClk = ~iClk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  typedef struct packed {
    logic [2:0]  exec;
    logic [3:0]  func;
    logic        bw;
    logic        sgn;
    logic [3:0]  sel;
    logic        s1mem;
    logic [1:0]  s2sel;
    logic [15:0] ea;
  } op_t;

  op_t         m_op      = '0;
  bit          m_pending = 0;  // an operation is held by the stage
  bit          m_needmem = 0;  // ...and it is still waiting for its memory operand
  logic [15:0] m_r1 = '0, m_r2 = '0;
  int          m_wait = 0;
  bit          m_rdy, m_vld;

  function automatic logic [15:0] ext(input logic [15:0] v, input logic bw, input logic sgn);
    if (bw) return v;
    if (sgn && v[7]) return (v & 16'h00FF) | 16'hFF00;
    return v & 16'h00FF;
  endfunction

  always @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      m_op = '0; m_pending = 0; m_needmem = 0; m_r1 = '0; m_r2 = '0; m_wait = 0;
    end else begin
      m_vld = m_pending && !m_needmem;
      m_rdy = !m_pending || (m_vld && iExReady);
      if (iFlush) begin
        m_pending = 0;
      end else if (m_pending && m_needmem) begin
        if (iMemAck) begin
          if (m_op.s1mem)      m_r1 = ext(iMemData, m_op.bw, m_op.sgn);
          if (m_op.s2sel == 2) m_r2 = ext(iMemData, m_op.bw, m_op.sgn);
          m_needmem = 0;
        end else begin
          m_wait = (m_wait >= 255) ? 255 : m_wait + 1;
        end
      end else if (iValid && m_rdy) begin
        m_op = '{iExec, iFunc, iBW, iSgn, iSelOut, iSrc1Mem, iSrc2Sel, iEA};
        m_pending = 1;
        m_needmem = iSrc1Mem || (iSrc2Sel == 2);
        if (!iSrc1Mem) m_r1 = ext(iRegA, iBW, iSgn);
        if (iSrc2Sel == 0) m_r2 = ext(iRegB, iBW, iSgn);
        if (iSrc2Sel == 1) m_r2 = ext(iImm, iBW, iSgn);
        if (iSrc2Sel == 3) m_r2 = 16'h0000;
        if (m_needmem) m_wait = 0;
      end else if (m_vld && iExReady) begin
        m_pending = 0;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  bit cmp_en = 0;
  bit e_vld, e_mrd, e_rdy;

  always @(negedge iClk) begin
    if (cmp_en) begin
      e_vld = m_pending && !m_needmem;
      e_mrd = m_pending && m_needmem;
      e_rdy = !m_pending || (e_vld && iExReady);
      check("oValid", oValid, e_vld);
      check("oMemRd", oMemRd, e_mrd);
      check("oReady", oReady, e_rdy);
      if (e_mrd) check("oMemAddr", oMemAddr, m_op.ea);
      check("R1", R1, m_r1);
      check("R2", R2, m_r2);
      check("oEA", oEA, m_op.ea);
      check("oExec", oExec, m_op.exec);
      check("oFunc", oFunc, m_op.func);
      check("oBW", oBW, m_op.bw);
      check("oSgn", oSgn, m_op.sgn);
      check("oSelOut", oSelOut, m_op.sel);
      check("oWaitCnt", oWaitCnt, m_wait[7:0]);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge iClk); #1;
  endtask

  task automatic mid();
    @(negedge iClk);
  endtask

  task automatic randomize_inputs();
    iValid   = ($urandom_range(0, 9) < 6);
    iExReady = ($urandom_range(0, 9) < 7);
    iMemAck  = ($urandom_range(0, 9) < 4);
    iFlush   = ($urandom_range(0, 24) == 0);
    iExec    = 3'($urandom);
    iFunc    = 4'($urandom);
    iBW      = 1'($urandom);
    iSgn     = 1'($urandom);
    iSelOut  = 4'($urandom);
    iSrc1Mem = ($urandom_range(0, 3) == 0);
    iSrc2Sel = 2'($urandom);
    iRegA    = 16'($urandom);
    iRegB    = 16'($urandom);
    iImm     = 16'($urandom);
    iEA      = 16'($urandom);
    iMemData = 16'($urandom);
  endtask

  initial begin
    iRst_n = 1'b0;
    iValid = 0; iBW = 0; iSgn = 0; iSrc1Mem = 0; iMemAck = 0; iFlush = 0; iExReady = 0;
    iExec = '0; iFunc = '0; iSelOut = '0; iSrc2Sel = '0;
    iRegA = '0; iRegB = '0; iImm = '0; iEA = '0; iMemData = '0;

    mid(); mid();
    check("rst_oValid", oValid, 0);
    check("rst_oMemRd", oMemRd, 0);
    check("rst_R1", R1, 0);
    check("rst_oWaitCnt", oWaitCnt, 0);
    check("rst_oReady", oReady, 1);
    #1 iRst_n = 1'b1; cmp_en = 1;

    // Register operation, then back-pressure with a new op waiting.
    step(); iValid = 1; iRegA = 16'h1234; iRegB = 16'h0F0F; iSrc2Sel = 0; iBW = 1;
            iExec = 3'd5; iFunc = 4'hA; iSelOut = 4'h3;
    mid();  check("reg_ready", oReady, 1);
    step(); iRegA = 16'h5555; iExec = 3'd2;
    mid();  check("reg_valid", oValid, 1); check("reg_R1", R1, 16'h1234);
            check("reg_R2", R2, 16'h0F0F); check("reg_exec", oExec, 5);
    for (int i = 0; i < 4; i++) begin
      step(); mid();
      check("bp_ready", oReady, 0); check("bp_R1", R1, 16'h1234); check("bp_exec", oExec, 5);
    end
    step(); iExReady = 1;
    mid();  check("bp_release_ready", oReady, 1);
    step(); iValid = 0;
    mid();  check("b2b_valid", oValid, 1); check("b2b_R1", R1, 16'h5555); check("b2b_exec", oExec, 2);

    // Byte mode, signed then unsigned, with zero operand 2.
    step(); iValid = 1; iBW = 0; iSgn = 1; iRegA = 16'h0085; iSrc2Sel = 3; iExReady = 0;
    mid();  check("idle_valid", oValid, 0);
    step(); iSgn = 0; iExReady = 1;
    mid();  check("byte_s_R1", R1, 16'hFF85); check("zero_R2", R2, 16'h0000);
    step(); iValid = 0;
    mid();  check("byte_u_R1", R1, 16'h0085);

    // Memory operand with three wait cycles.
    step(); iValid = 1; iSrc1Mem = 0; iSrc2Sel = 2; iEA = 16'h0200; iRegA = 16'h1111;
            iBW = 1; iExReady = 0;
    mid();  check("mem_idle_valid", oValid, 0);
    step(); iValid = 0;
    mid();  check("mem_rd", oMemRd, 1); check("mem_addr", oMemAddr, 16'h0200);
            check("mem_wait0", oWaitCnt, 0); check("mem_ready", oReady, 0);
    step(); step();
    step(); iMemAck = 1; iMemData = 16'hABCD;
    mid();  check("mem_wait3", oWaitCnt, 3); check("mem_rd_at_ack", oMemRd, 1);
    step(); iMemAck = 0;
    mid();  check("mem_valid", oValid, 1); check("mem_R2", R2, 16'hABCD);
            check("mem_R1", R1, 16'h1111); check("mem_rd_drop", oMemRd, 0);
            check("mem_wait_hold", oWaitCnt, 3); check("mem_ea", oEA, 16'h0200);
    step(); iExReady = 1;
    mid();

    // Zero-wait read filling operand 1.
    step(); iValid = 1; iSrc1Mem = 1; iSrc2Sel = 1; iImm = 16'h0042; iEA = 16'h0300;
    step(); iValid = 0; iMemAck = 1; iMemData = 16'h1357;
    mid();  check("zw_rd", oMemRd, 1); check("zw_addr", oMemAddr, 16'h0300); check("zw_wait", oWaitCnt, 0);
    step(); iMemAck = 0;
    mid();  check("zw_valid", oValid, 1); check("zw_R1", R1, 16'h1357); check("zw_R2", R2, 16'h0042);

    // Flush with a simultaneous ack, then flush blocking an acceptance.
    step(); iValid = 1; iSrc1Mem = 0; iSrc2Sel = 2; iRegA = 16'h2222; iEA = 16'h0400;
    step(); iFlush = 1; iMemAck = 1; iMemData = 16'hFFFF; iRegA = 16'h7777; iSrc2Sel = 0;
    mid();  check("fl_rd_before", oMemRd, 1);
    step(); iMemAck = 0;
    mid();  check("fl_rd", oMemRd, 0); check("fl_valid", oValid, 0);
            check("fl_R1", R1, 16'h2222); check("fl_R2", R2, 16'h0042);
    step(); iFlush = 0; iValid = 0;
    mid();  check("fl_noaccept_valid", oValid, 0); check("fl_noaccept_R1", R1, 16'h2222);

    // Stray ack while idle.
    step(); iMemAck = 1;
    step(); iMemAck = 0;
    mid();  check("stray_valid", oValid, 0); check("stray_R2", R2, 16'h0042);

    // Reset during a read abandons it; a later ack is ignored.
    step(); iValid = 1; iSrc2Sel = 2; iEA = 16'h0500;
    step(); iValid = 0;
    #1 iRst_n = 1'b0;
    #1 check("rst_mem_rd", oMemRd, 0); check("rst_mem_addr", oMemAddr, 0);
    mid(); #1 iRst_n = 1'b1; iMemAck = 1;
    step(); iMemAck = 0;
    mid();  check("post_rst_rd", oMemRd, 0); check("post_rst_valid", oValid, 0); check("post_rst_R2", R2, 0);

    // Asynchronous reset while holding a valid operation.
    step(); iValid = 1; iSrc2Sel = 1; iImm = 16'h0099; iExReady = 0;
    step(); iValid = 0;
    check("hold_valid", oValid, 1); check("hold_R2", R2, 16'h0099);
    #2 iRst_n = 1'b0;
    #1 check("async_valid", oValid, 0); check("async_R2", R2, 0); check("async_exec", oExec, 0);
    mid(); #1 iRst_n = 1'b1;

    // Wait counter saturation.
    step(); iValid = 1; iSrc1Mem = 1; iSrc2Sel = 0; iEA = 16'h0600; iExReady = 1; iBW = 1;
    step(); iValid = 0;
    repeat (300) step();
    mid();  check("sat_wait", oWaitCnt, 255); check("sat_rd", oMemRd, 1);
    step(); iMemAck = 1; iMemData = 16'h8001;
    step(); iMemAck = 0;
    mid();  check("sat_valid", oValid, 1); check("sat_R1", R1, 16'h8001); check("sat_wait_hold", oWaitCnt, 255);

    // Randomized traffic with occasional asynchronous resets.
    for (int c = 0; c < 3000; c++) begin
      step();
      randomize_inputs();
      if ($urandom_range(0, 599) == 0) begin
        #1 iRst_n = 1'b0;
        mid(); #1 iRst_n = 1'b1;
      end
    end

    step();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
